// File: rtl/weather_event_logger.sv
// weather_event_logger: timestamps each change of the detector result bus into a FWFT FIFO and keeps min/max/overflow stats
// Ports: CLK, Reset (async, active-high); din = detector result bus; rd_en pops the FIFO head;
// clear_stats clears min/max/stats_valid/overflow; dout = {timestamp, value} head (0 while empty);
// empty/full/level = FIFO occupancy; overflow = sticky drop flag; min_val/max_val/stats_valid = event statistics.
module weather_event_logger #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int TSW   = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [7:0]       din,
  input  logic             rd_en,
  input  logic             clear_stats,
  output logic [TSW+7:0]   dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level,
  output logic             overflow,
  output logic [7:0]       min_val,
  output logic [7:0]       max_val,
  output logic             stats_valid
);
  logic [7:0]     prev;
  logic [TSW-1:0] ts;
  logic [TSW+7:0] mem [DEPTH];
  logic [AW-1:0]  wp, rp;
  logic           ev, pop, push, drop;
  logic [AW:0]    level_n;
  assign ev      = din != prev;
  assign pop     = rd_en & ~empty;
  // a pop in the same cycle frees the slot a full FIFO would otherwise lack
  assign push    = ev & (~full | pop);
  assign drop    = ev & full & ~pop;
  assign level_n = level + (AW+1)'(push) - (AW+1)'(pop);
  assign dout    = empty ? '0 : mem[rp];
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      prev        <= '0;
      ts          <= '0;
      wp          <= '0;
      rp          <= '0;
      level       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      overflow    <= 1'b0;
      min_val     <= 8'hFF;
      max_val     <= 8'h00;
      stats_valid <= 1'b0;
    end else begin
      prev        <= din;
      ts          <= ts + 1'b1;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      level       <= level_n;
      empty       <= level_n == '0;
      full        <= level_n == (AW+1)'(DEPTH);
      overflow    <= drop | (overflow & ~clear_stats);
      // a clear coinciding with an event restarts the statistics from that event
      min_val     <= clear_stats ? (ev ? din : 8'hFF) : (ev && din < min_val ? din : min_val);
      max_val     <= clear_stats ? (ev ? din : 8'h00) : (ev && din > max_val ? din : max_val);
      stats_valid <= ev | (stats_valid & ~clear_stats);
    end
  end
  always_ff @(posedge CLK) if (push) mem[wp] <= {ts, din};
endmodule
